conv_pixel_loader: RTL and testbench
====================================

Name: conv_pixel_loader

Overview:
- Downstream consumer of the Nios II system's software-driven PIO outputs: data_out[7:0], write_en, start_bit and reset_cnt.
- Captures one pixel per write_en rising edge and stores the previous two image rows in line buffers.
- Emits a 3x3 pixel window plus a one-cycle valid pulse to the convolution filter datapath.
- Shares the system clock with the Nios II system, so inputs are same-domain; they are registered once for edge detection only.

Parameters:
- IMG_WIDTH, 64, pixels per row (>=3).
- IMG_HEIGHT, 64, rows per frame (>=3).
- PIX_W, 8, bits per pixel.

Ports:
- clk_clk  in  1  system clock; all logic on the rising edge.
- reset_reset_n  in  1  asynchronous, active-low reset.
- data_in  in  PIX_W  pixel value from the data_out PIO.
- write_en  in  1  level from PIO; each rising edge = one pixel.
- start_bit  in  1  level from PIO; a rising edge arms a frame.
- reset_cnt  in  1  level; while high, synchronous clear of counters and state.
- window  out  9*PIX_W  3x3 window; [9*PIX_W-1 -: PIX_W] = top-left, [PIX_W-1:0] = bottom-right (newest), row-major.
- win_valid  out  1  one-cycle pulse: window holds a new full window.
- busy  out  1  high in LOAD.
- frame_done  out  1  high in DONE.
- row_cnt  out  clog2(IMG_HEIGHT)  row of the next pixel to accept.
- col_cnt  out  clog2(IMG_WIDTH)  column of the next pixel to accept.

Behaviour:
- Reset (async, reset_reset_n=0):
  - State=IDLE; all outputs 0; edge registers 0.
  - Line buffers and window registers cleared to 0.
- Edge detect: registers we_q and st_q.
  - we_rise = write_en & ~we_q.
  - st_rise = start_bit & ~st_q.
  - A level held high produces exactly one event.
- States:
  - IDLE: st_rise -> LOAD and counters cleared. we_rise is ignored.
  - LOAD: we_rise accepts data_in (see Accept). Accepting pixel IMG_WIDTH*IMG_HEIGHT-1 -> DONE. st_rise is ignored.
  - DONE: st_rise -> LOAD with counters cleared. we_rise is ignored.
- Priority, per cycle: reset_cnt > st_rise > we_rise.
  - reset_cnt=1: state -> IDLE, counters cleared, win_valid=0, events ignored.
  - Line buffer contents are kept on reset_cnt.
  - In IDLE, st_rise and we_rise in the same cycle: start is taken, pixel is dropped.
- Accept, in the cycle where we_rise is seen in LOAD:
  - data_in is shifted into the bottom line buffer.
  - The pixel leaving each line buffer shifts into the line buffer above.
  - Each window row shifts left by one pixel; the new column is {top line buffer out, middle line buffer out, data_in}.
  - col_cnt increments and wraps to 0 at IMG_WIDTH-1, which increments row_cnt.
- Window validity:
  - win_valid is asserted on the clock edge after accept when the accepted pixel had row>=2 and col>=2.
  - Latency from the we_rise cycle is 1 clock; the window is stable until the next accept.
- Row boundaries: windows are never emitted for col<2, so windows never straddle rows. There is no padding.
- Last pixel: win_valid and frame_done rise on the same edge; busy falls on that edge.
- Accepting the next pixel requires a new we_rise, so back-to-back accepts are at most every 2 cycles.
- Arithmetic: counters are unsigned and wrap only as stated.

Optional Feature:
- Macro: CONV_LOADER_WINCNT_EN.
- Defined:
  - Adds output win_cnt[15:0], counting win_valid pulses in the current frame.
  - Cleared by reset, reset_cnt and st_rise.
  - Saturates at 16'hFFFF.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=4. Pulse start_bit, then feed pixels 0..15 via write_en pulses:
  - 4 win_valid pulses.
  - First window = {0,1,2,4,5,6,8,9,10}; last window = {5,6,7,9,10,11,13,14,15}.
  - frame_done=1 after pixel 15.
- write_en held high for 10 cycles in LOAD -> exactly one pixel accepted; col_cnt advances by 1.
- reset_cnt pulsed after 7 pixels:
  - state=IDLE, busy=0, row_cnt=col_cnt=0.
  - Later write_en pulses without start_bit are ignored.
- start_bit and write_en rise in the same cycle in IDLE -> busy=1, col_cnt=0 (pixel dropped).
- reset_reset_n asserted mid-frame, asynchronously between edges -> all outputs 0 immediately; after release, state is IDLE.
- With CONV_LOADER_WINCNT_EN defined:
  - 4x4 frame -> win_cnt=4.
  - A second start_bit clears win_cnt to 0.

Source files
------------

// File: rtl/conv_pixel_loader.sv
// Pixel loader for a 3x3 convolution: captures PIO-driven pixels and forms sliding windows.
// Optional macro CONV_LOADER_WINCNT_EN adds a saturating per-frame window counter (win_cnt).
module conv_pixel_loader #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int PIX_W      = 8
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  input  logic [PIX_W-1:0]              data_in,
  input  logic                          write_en,
  input  logic                          start_bit,
  input  logic                          reset_cnt,
  output logic [9*PIX_W-1:0]            window,
  output logic                          win_valid,
  output logic                          busy,
  output logic                          frame_done,
`ifdef CONV_LOADER_WINCNT_EN
  output logic [15:0]                   win_cnt,
`endif
  output logic [$clog2(IMG_HEIGHT)-1:0] row_cnt,
  output logic [$clog2(IMG_WIDTH)-1:0]  col_cnt
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t           r_state, w_next;
  logic             r_we_q, r_st_q;
  logic             w_we_rise, w_st_rise;
  logic             w_start, w_accept, w_last;
  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  logic             r_win_valid;
  logic [PIX_W-1:0] r_lb_bot [IMG_WIDTH];
  logic [PIX_W-1:0] r_lb_top [IMG_WIDTH];
  logic [PIX_W-1:0] r_win    [9];
  logic [PIX_W-1:0] w_mid_out, w_top_out;

  assign w_we_rise = write_en & ~r_we_q;
  assign w_st_rise = start_bit & ~r_st_q;
  assign w_last    = (r_row == RW'(IMG_HEIGHT-1)) && (r_col == CW'(IMG_WIDTH-1));
  assign w_mid_out = r_lb_bot[IMG_WIDTH-1];
  assign w_top_out = r_lb_top[IMG_WIDTH-1];

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_we_q  <= 1'b0;
      r_st_q  <= 1'b0;
      r_state <= IDLE;
    end else begin
      r_we_q  <= write_en;
      r_st_q  <= start_bit;
      r_state <= w_next;
    end
  end

  // Priority: reset_cnt, then start, then pixel write; start wins over a same-cycle write.
  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_accept = 1'b0;
    if (reset_cnt) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_st_rise) begin
            w_next  = LOAD;
            w_start = 1'b1;
          end
        end
        LOAD: begin
          if (w_we_rise) begin
            w_accept = 1'b1;
            if (w_last) w_next = DONE;
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_col       <= '0;
      r_row       <= '0;
      r_win_valid <= 1'b0;
    end else begin
      r_win_valid <= 1'b0;
      if (reset_cnt || w_start) begin
        r_col <= '0;
        r_row <= '0;
      end else if (w_accept) begin
        r_win_valid <= (r_row >= RW'(2)) && (r_col >= CW'(2));
        if (r_col == CW'(IMG_WIDTH-1)) begin
          r_col <= '0;
          r_row <= (r_row == RW'(IMG_HEIGHT-1)) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  // Line buffers and window advance together; window rows take {top, mid, new}.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < IMG_WIDTH; i++) begin
        r_lb_bot[i] <= '0;
        r_lb_top[i] <= '0;
      end
      for (int k = 0; k < 9; k++) r_win[k] <= '0;
    end else if (w_accept) begin
      r_lb_bot[0] <= data_in;
      r_lb_top[0] <= w_mid_out;
      for (int i = 1; i < IMG_WIDTH; i++) begin
        r_lb_bot[i] <= r_lb_bot[i-1];
        r_lb_top[i] <= r_lb_top[i-1];
      end
      for (int r = 0; r < 3; r++) begin
        r_win[r*3+0] <= r_win[r*3+1];
        r_win[r*3+1] <= r_win[r*3+2];
      end
      r_win[2] <= w_top_out;
      r_win[5] <= w_mid_out;
      r_win[8] <= data_in;
    end
  end

`ifdef CONV_LOADER_WINCNT_EN
  logic [15:0] r_win_cnt;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_win_cnt <= '0;
    end else if (reset_cnt || w_start) begin
      r_win_cnt <= '0;
    end else if (r_win_valid && (r_win_cnt != 16'hFFFF)) begin
      r_win_cnt <= r_win_cnt + 16'd1;
    end
  end

  assign win_cnt = r_win_cnt;
`endif

  always_comb begin
    window = '0;
    for (int k = 0; k < 9; k++) window[(9-k)*PIX_W-1 -: PIX_W] = r_win[k];
  end

  assign win_valid  = r_win_valid;
  assign busy       = (r_state == LOAD);
  assign frame_done = (r_state == DONE);
  assign row_cnt    = r_row;
  assign col_cnt    = r_col;

endmodule

// File: tb/tb_conv_pixel_loader.sv
// Scoreboard bench for conv_pixel_loader on a 4x4 image; win_cnt checked when CONV_LOADER_WINCNT_EN is defined.
module tb_conv_pixel_loader;
  localparam int W = 4;
  localparam int H = 4;
  localparam int P = 8;

  logic           clk = 1'b0;
  logic           reset_reset_n;
  logic [P-1:0]   data_in;
  logic           write_en, start_bit, reset_cnt;
  logic [9*P-1:0] window;
  logic           win_valid, busy, frame_done;
  logic [1:0]     row_cnt, col_cnt;
`ifdef CONV_LOADER_WINCNT_EN
  logic [15:0]    win_cnt;
`endif

  conv_pixel_loader #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(P)) dut (
    .clk_clk(clk), .reset_reset_n(reset_reset_n), .data_in(data_in),
    .write_en(write_en), .start_bit(start_bit), .reset_cnt(reset_cnt),
    .window(window), .win_valid(win_valid), .busy(busy), .frame_done(frame_done),
`ifdef CONV_LOADER_WINCNT_EN
    .win_cnt(win_cnt),
`endif
    .row_cnt(row_cnt), .col_cnt(col_cnt)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  int n_exp  = 0;
  int n_seen = 0;
  logic [9*P-1:0] exp_q[$];
  logic [9*P-1:0] win_tbl [4];

  task automatic check(input string name, input logic [9*P-1:0] act, input logic [9*P-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input logic [P-1:0] d, input logic exp_v);
    if (exp_v) begin
      exp_q.push_back(win_tbl[n_exp]);
      n_exp++;
    end
    data_in  = d;
    write_en = 1'b1;
    step();
    check("win_valid_latency", {71'd0, win_valid}, {71'd0, exp_v});
    write_en = 1'b0;
    step();
  endtask

  task automatic start_pulse();
    start_bit = 1'b1;
    step();
    start_bit = 1'b0;
  endtask

  always @(negedge clk) begin
    if (win_valid) begin
      n_seen++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_window: got %0h, expected no win_valid", window);
      end else begin
        check("window", window, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    win_tbl[0] = {8'd0, 8'd1, 8'd2, 8'd4,  8'd5,  8'd6,  8'd8,  8'd9,  8'd10};
    win_tbl[1] = {8'd1, 8'd2, 8'd3, 8'd5,  8'd6,  8'd7,  8'd9,  8'd10, 8'd11};
    win_tbl[2] = {8'd4, 8'd5, 8'd6, 8'd8,  8'd9,  8'd10, 8'd12, 8'd13, 8'd14};
    win_tbl[3] = {8'd5, 8'd6, 8'd7, 8'd9,  8'd10, 8'd11, 8'd13, 8'd14, 8'd15};
    reset_reset_n = 1'b0;
    data_in = '0; write_en = 1'b0; start_bit = 1'b0; reset_cnt = 1'b0;
    step(); step();
    check("rst_busy", {71'd0, busy}, '0);
    check("rst_frame_done", {71'd0, frame_done}, '0);
    check("rst_win_valid", {71'd0, win_valid}, '0);
    check("rst_window", window, '0);
    check("rst_row_col", {68'd0, row_cnt, col_cnt}, '0);
    reset_reset_n = 1'b1;
    step();

    // Full 4x4 frame: pixels 0..15
    start_pulse();
    check("start_busy", {71'd0, busy}, 72'd1);
    step();
    for (int i = 0; i < 16; i++) pixel(P'(i), (i / W >= 2) && (i % W >= 2));
    check("last_frame_done", {71'd0, frame_done}, 72'd1);
    check("last_busy", {71'd0, busy}, '0);
    check("last_row_col", {68'd0, row_cnt, col_cnt}, '0);
`ifdef CONV_LOADER_WINCNT_EN
    check("win_cnt_frame", {56'd0, win_cnt}, 72'd4);
`endif

    // Restart from DONE, hold write_en high for 10 cycles
    start_pulse();
    check("restart_busy", {71'd0, busy}, 72'd1);
    check("restart_frame_done", {71'd0, frame_done}, '0);
`ifdef CONV_LOADER_WINCNT_EN
    check("win_cnt_cleared", {56'd0, win_cnt}, '0);
`endif
    step();
    data_in = 8'h50;
    write_en = 1'b1;
    repeat (10) step();
    write_en = 1'b0;
    step();
    check("hold_col", {70'd0, col_cnt}, 72'd1);
    for (int i = 0; i < 6; i++) pixel(P'(8'h60 + i), 1'b0);
    check("seven_row_col", {68'd0, row_cnt, col_cnt}, {68'd0, 2'd1, 2'd3});

    // reset_cnt after 7 pixels
    reset_cnt = 1'b1;
    step();
    reset_cnt = 1'b0;
    check("rcnt_busy", {71'd0, busy}, '0);
    check("rcnt_row_col", {68'd0, row_cnt, col_cnt}, '0);
    pixel(8'h77, 1'b0);
    pixel(8'h78, 1'b0);
    check("idle_we_col", {70'd0, col_cnt}, '0);
    check("idle_we_busy", {71'd0, busy}, '0);

    // start and write rise together in IDLE
    start_bit = 1'b1;
    write_en  = 1'b1;
    data_in   = 8'hAA;
    step();
    check("same_cycle_busy", {71'd0, busy}, 72'd1);
    check("same_cycle_col", {70'd0, col_cnt}, '0);
    start_bit = 1'b0;
    write_en  = 1'b0;
    step();
    for (int i = 0; i < 3; i++) pixel(P'(8'h20 + i), 1'b0);
    check("pre_areset_col", {70'd0, col_cnt}, 72'd3);

    // Asynchronous reset between edges
    #2;
    reset_reset_n = 1'b0;
    #1;
    check("areset_busy", {71'd0, busy}, '0);
    check("areset_col", {70'd0, col_cnt}, '0);
    check("areset_window", window, '0);
    check("areset_frame_done", {71'd0, frame_done}, '0);
    step();
    reset_reset_n = 1'b1;
    step();
    pixel(8'h33, 1'b0);
    check("post_areset_busy", {71'd0, busy}, '0);
    check("post_areset_col", {70'd0, col_cnt}, '0);

    step();
    check("window_count", n_seen, n_exp);
    check("queue_empty", exp_q.size(), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
